// File: rtl/instr_fetch_queue.sv
// ============================================================================
// Module   : instr_fetch_queue
// Purpose  : Decoupled instruction fetch. Owns the PC, issues req/ack fetches,
//            queues instructions with PCs, and applies downstream redirects.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_queue #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter int                    DEPTH       = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    input  logic                   instr_ready,
    input  logic                   redir_valid,
    input  logic [1:0]             redir_kind,
    input  logic [ADDR_WIDTH-1:0]  redir_base_pc,
    input  logic [15:0]            redir_imm16,
    input  logic [25:0]            redir_target26,
    input  logic [ADDR_WIDTH-1:0]  redir_reg
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        ST_FETCH   = 1'b0,
        ST_DISCARD = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_req_en;
    logic [ADDR_WIDTH-1:0]   r_fetch_pc;
    logic [ADDR_WIDTH-1:0]   r_pend_pc;
    logic [ADDR_WIDTH-1:0]   w_fetch_pc_nxt;
    logic [ADDR_WIDTH-1:0]   w_pend_pc_nxt;
    logic [CNT_W-1:0]        r_count;
    logic [CNT_W-1:0]        w_count_nxt;
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [INSTR_WIDTH-1:0]  r_instr_q [DEPTH];
    logic [ADDR_WIDTH-1:0]   r_pc_q    [DEPTH];

    logic                    w_redir_take;
    logic [ADDR_WIDTH-1:0]   w_base_inc;
    logic [ADDR_WIDTH-1:0]   w_target;
    logic                    w_fire;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_flush;

    // Redirect target computation; kind 3 is reserved and never taken.
    assign w_redir_take = redir_valid && (redir_kind != 2'd3);
    assign w_base_inc   = redir_base_pc + ADDR_WIDTH'(1);

    always_comb begin
        w_target = redir_reg;
        case (redir_kind)
            2'd0:    w_target = w_base_inc + {{(ADDR_WIDTH-16){redir_imm16[15]}}, redir_imm16};
            2'd1:    w_target = {w_base_inc[ADDR_WIDTH-1:26], redir_target26};
            default: w_target = redir_reg;
        endcase
    end

    // Request depends only on registered state so ack can never loop back into it.
    assign imem_req  = r_req_en && ((r_state == ST_DISCARD) || (r_count < c_depth));
    assign imem_addr = r_fetch_pc;
    assign w_fire    = imem_req && imem_ack;

    assign instr_valid = (r_count != '0) && !redir_valid;
    assign instr       = r_instr_q[r_rd_ptr];
    assign instr_pc    = r_pc_q[r_rd_ptr];
    assign w_pop       = instr_valid && instr_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_pend_pc_nxt  = r_pend_pc;
        w_push         = 1'b0;
        w_flush        = w_redir_take;
        case (r_state)
            ST_FETCH: begin
                if (w_redir_take) begin
                    if (imem_req && !imem_ack) begin
                        // The in-flight request cannot be retracted; drain it first.
                        w_state_nxt   = ST_DISCARD;
                        w_pend_pc_nxt = w_target;
                    end else begin
                        w_fetch_pc_nxt = w_target;
                    end
                end else if (w_fire) begin
                    w_push         = 1'b1;
                    w_fetch_pc_nxt = r_fetch_pc + ADDR_WIDTH'(1);
                end
            end
            ST_DISCARD: begin
                if (w_redir_take) begin
                    w_pend_pc_nxt = w_target;
                end
                if (w_fire) begin
                    w_state_nxt    = ST_FETCH;
                    w_fetch_pc_nxt = w_redir_take ? w_target : r_pend_pc;
                end
            end
            default: w_state_nxt = ST_FETCH;
        endcase
    end

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_FETCH;
            r_req_en   <= 1'b0;
            r_fetch_pc <= RESET_PC;
            r_pend_pc  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_req_en   <= 1'b1;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_pend_pc  <= w_pend_pc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_instr_q[i] <= '0;
                r_pc_q[i]    <= '0;
            end
        end else if (w_flush) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_instr_q[r_wr_ptr] <= imem_rdata;
                r_pc_q[r_wr_ptr]    <= r_fetch_pc;
                r_wr_ptr            <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
        end
    end

endmodule

`default_nettype wire

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Parametrised, decoupled successor to the single-cycle fetch unit: owns the word-addressed program counter, issues sequential fetches to instruction memory over a req/ack handshake, buffers returned instructions with their PCs in a DEPTH-entry queue, and serves them to decode over valid/ready. Branch (PC-relative), jump (pseudo-absolute) and jump-register redirects arrive from downstream, flush the queue and restart fetch at the computed target. It sits between instruction memory and the decode stage of the pipelined CPU.

## Interface
- ADDR_WIDTH, 32, PC width in words; must be >= 27
- INSTR_WIDTH, 32, instruction width
- DEPTH, 4, queue entries; power of two, >= 2
- RESET_PC, 0, fetch PC after reset
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_WIDTH  word address of request
- imem_ack  in  1  memory accepts request and returns data this cycle
- imem_rdata  in  INSTR_WIDTH  instruction, valid when imem_ack
- instr_valid  out  1  queue head valid
- instr  out  INSTR_WIDTH  head instruction
- instr_pc  out  ADDR_WIDTH  PC of head instruction
- instr_ready  in  1  decode consumes head when instr_valid && instr_ready
- redir_valid  in  1  taken control transfer this cycle
- redir_kind  in  2  0 branch, 1 jump, 2 jump-register, 3 reserved (ignored, no flush)
- redir_base_pc  in  ADDR_WIDTH  PC of redirecting instruction
- redir_imm16  in  16  branch offset, words, signed
- redir_target26  in  26  jump target field
- redir_reg  in  ADDR_WIDTH  jump-register target

## Operation
- Targets, all modulo 2^ADDR_WIDTH: branch = base_pc + 1 + sext(imm16); jump = {(base_pc+1)[ADDR_WIDTH-1:26], target26}; jump-register = redir_reg.
- Sequential fetch: fetch_pc increments by 1 on each accepted (acked, not discarded) request; wraps from all-ones to 0.
- States: FETCH, DISCARD.
- FETCH: imem_req = (count < DEPTH); imem_addr = fetch_pc. On imem_ack: push {imem_rdata, fetch_pc}, fetch_pc += 1.
- Handshake: once imem_req is high without ack, imem_req and imem_addr hold stable until ack (no retraction, even on redirect). At most one request outstanding.
- Redirect (valid kind) in FETCH: queue flushed (count = 0); fetch_pc = target.
  - No request pending, or imem_ack same cycle: ack data dropped, stay FETCH.
  - Request pending without ack: go DISCARD; target held in pending register.
- DISCARD: imem_req held high at old address; on ack, data dropped, fetch_pc = pending target, return FETCH. Further redirects in DISCARD overwrite the pending target; queue stays empty.
- Output: instr_valid = (count != 0) && !redir_valid; instr/instr_pc = head entry. Pop only when instr_valid && instr_ready.
- Push and pop in same cycle allowed; count unchanged. Push never occurs when full (request gated on count < DEPTH and single outstanding).
- Queue read/write pointers wrap modulo DEPTH.
- Reset (rst_n low at edge): fetch_pc = RESET_PC, state FETCH, count 0, pointers 0, storage cleared; overrides any redirect, ack or pending request. Memory must drop an in-flight request on reset.

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, instr_valid 0, instr 0, instr_pc 0. imem_req is registered-enable: low in the reset cycle and first high the cycle after rst_n is sampled high.
- Ack may arrive in the same cycle as request (zero-wait memory) or any later cycle.
- Fetch-to-decode latency: instruction acked in cycle N is visible at instr_valid in N+1.
- Sustained throughput with zero-wait memory and instr_ready held high: one instruction per cycle.
- Redirect in cycle N, nothing pending: imem_req at target in N+1; first target instruction valid at N+2 with zero-wait memory.
- Redirect with pending request: target fetch issued the cycle after the discarded ack.
- imem_addr/imem_req depend only on registered state and count; no combinational path from imem_ack to imem_req.

## Test plan
- Reset, RESET_PC=0x100, zero-wait memory, ready high -> imem_req first in cycle after rst_n rises; instr_pc stream 0x100, 0x101, 0x102 one per cycle from N+1.
- ready low, DEPTH=4 -> exactly 4 entries pushed, imem_req drops; ready high one cycle -> one pop, one new request at next PC.
- Branch base_pc=0x20, imm16=0xFFFE -> next fetch addr 0x1F; jump base 0x0400_0010, target26=0x123 -> 0x0400_0123; jr redir_reg=0x55 -> 0x55; queue empty, instr_valid low during redirect cycle.
- 3-cycle ack memory, redirect while request pending at 0x10 -> imem_addr held 0x10 until ack, data dropped, then req at target; second redirect in DISCARD -> only the later target fetched.
- fetch_pc=0x3FFFFFFF (ADDR_WIDTH=30) -> next fetch 0x0; redirect coinciding with ack -> acked word never appears at instr.
- rst_n low mid-stream with pending request and redir_valid -> next cycle instr_valid 0, imem_req 0, imem_addr RESET_PC.
